// File: rtl/choose.sv
`default_nettype none
// ============================================================================
// Module      : choose
// Description : Priority RGB layer selector. Three layers each offer an RGB
//               triple with a request flag; the lowest-indexed requesting
//               layer wins and its colour is registered to the output. With
//               no request a fixed background colour is registered instead.
// Revision    : 1.0 - initial release
// ============================================================================
module choose #(
  parameter int                DATA_W   = 8,
  parameter logic [DATA_W-1:0] BG_RED   = 8'h00,
  parameter logic [DATA_W-1:0] BG_GREEN = 8'h00,
  parameter logic [DATA_W-1:0] BG_BLUE  = 8'h00
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              RqFLag0,
  input  logic              RqFLag1,
  input  logic              RqFLag2,
  input  logic [DATA_W-1:0] r0,
  input  logic [DATA_W-1:0] g0,
  input  logic [DATA_W-1:0] b0,
  input  logic [DATA_W-1:0] r1,
  input  logic [DATA_W-1:0] g1,
  input  logic [DATA_W-1:0] b1,
  input  logic [DATA_W-1:0] r2,
  input  logic [DATA_W-1:0] g2,
  input  logic [DATA_W-1:0] b2,
  output logic [DATA_W-1:0] red,
  output logic [DATA_W-1:0] green,
  output logic [DATA_W-1:0] blue,
  output logic [1:0]        sel,
  output logic              active
);

  // Encodings presented on sel.
  localparam logic [1:0] SEL_L0 = 2'd0;
  localparam logic [1:0] SEL_L1 = 2'd1;
  localparam logic [1:0] SEL_L2 = 2'd2;
  localparam logic [1:0] SEL_BG = 2'd3;

  logic [DATA_W-1:0] red_d,   red_q;
  logic [DATA_W-1:0] green_d, green_q;
  logic [DATA_W-1:0] blue_d,  blue_q;
  logic [1:0]        sel_d,   sel_q;
  logic              active_d, active_q;

  // Priority pick: layer 0 over 1 over 2, background when nobody requests.
  always_comb begin
    red_d    = BG_RED;
    green_d  = BG_GREEN;
    blue_d   = BG_BLUE;
    sel_d    = SEL_BG;
    active_d = 1'b0;
    if (RqFLag0) begin
      red_d    = r0;
      green_d  = g0;
      blue_d   = b0;
      sel_d    = SEL_L0;
      active_d = 1'b1;
    end else if (RqFLag1) begin
      red_d    = r1;
      green_d  = g1;
      blue_d   = b1;
      sel_d    = SEL_L1;
      active_d = 1'b1;
    end else if (RqFLag2) begin
      red_d    = r2;
      green_d  = g2;
      blue_d   = b2;
      sel_d    = SEL_L2;
      active_d = 1'b1;
    end
  end

  // Output register; reset clears to black/background-select, not BG colour.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      red_q    <= '0;
      green_q  <= '0;
      blue_q   <= '0;
      sel_q    <= SEL_BG;
      active_q <= 1'b0;
    end else begin
      red_q    <= red_d;
      green_q  <= green_d;
      blue_q   <= blue_d;
      sel_q    <= sel_d;
      active_q <= active_d;
    end
  end

  assign red    = red_q;
  assign green  = green_q;
  assign blue   = blue_q;
  assign sel    = sel_q;
  assign active = active_q;

endmodule
`default_nettype wire

// File: tb/tb_choose.sv
`default_nettype none
// ============================================================================
// Module      : tb_choose
// Description : Scoreboard bench for choose. Stimulus pushes the expected
//               registered response; a monitor pops it one edge later.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_choose;

  localparam logic [7:0] BG_R = 8'h5A;
  localparam logic [7:0] BG_G = 8'hC3;
  localparam logic [7:0] BG_B = 8'h0F;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic [1:0] s;
    logic       a;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       RqFLag0, RqFLag1, RqFLag2;
  logic [7:0] r0, g0, b0, r1, g1, b1, r2, g2, b2;
  logic [7:0] red, green, blue;
  logic [1:0] sel;
  logic       active;

  int   total = 0;
  int   bad   = 0;
  exp_t q[$];

  choose #(
    .DATA_W   (8),
    .BG_RED   (BG_R),
    .BG_GREEN (BG_G),
    .BG_BLUE  (BG_B)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .RqFLag0 (RqFLag0),
    .RqFLag1 (RqFLag1),
    .RqFLag2 (RqFLag2),
    .r0      (r0),
    .g0      (g0),
    .b0      (b0),
    .r1      (r1),
    .g1      (g1),
    .b1      (b1),
    .r2      (r2),
    .g2      (g2),
    .b2      (b2),
    .red     (red),
    .green   (green),
    .blue    (blue),
    .sel     (sel),
    .active  (active)
  );

  always #5 clk = ~clk;

  // Reference: first requesting layer in index order, else background.
  function automatic exp_t model(input logic [2:0] f,
                                 input logic [2:0][7:0] rv,
                                 input logic [2:0][7:0] gv,
                                 input logic [2:0][7:0] bv);
    exp_t e;
    e = '{r: BG_R, g: BG_G, b: BG_B, s: 2'd3, a: 1'b0};
    for (int i = 0; i < 3; i++) begin
      if (f[i]) begin
        e = '{r: rv[i], g: gv[i], b: bv[i], s: 2'(i), a: 1'b1};
        break;
      end
    end
    return e;
  endfunction

  function automatic exp_t dut_out();
    return '{r: red, g: green, b: blue, s: sel, a: active};
  endfunction

  task automatic check(input string name, input exp_t act, input exp_t want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got rgb=%h/%h/%h sel=%0d act=%b, want rgb=%h/%h/%h sel=%0d act=%b",
               name, act.r, act.g, act.b, act.s, act.a,
               want.r, want.g, want.b, want.s, want.a);
    end
  endtask

  task automatic check_reset(input string name);
    check(name, dut_out(), '{r: 8'h00, g: 8'h00, b: 8'h00, s: 2'd3, a: 1'b0});
  endtask

  // Drive one set of inputs and record what the next edge must produce.
  task automatic set_inputs(input logic [2:0] f,
                            input logic [2:0][7:0] rv,
                            input logic [2:0][7:0] gv,
                            input logic [2:0][7:0] bv);
    RqFLag0 = f[0]; RqFLag1 = f[1]; RqFLag2 = f[2];
    r0 = rv[0]; g0 = gv[0]; b0 = bv[0];
    r1 = rv[1]; g1 = gv[1]; b1 = bv[1];
    r2 = rv[2]; g2 = gv[2]; b2 = bv[2];
    q.push_back(model(f, rv, gv, bv));
  endtask

  task automatic rand_colours(output logic [2:0][7:0] rv,
                              output logic [2:0][7:0] gv,
                              output logic [2:0][7:0] bv);
    for (int i = 0; i < 3; i++) begin
      rv[i] = 8'($urandom);
      gv[i] = 8'($urandom);
      bv[i] = 8'($urandom);
    end
  endtask

  task automatic rand_inputs();
    logic [2:0][7:0] rv, gv, bv;
    rand_colours(rv, gv, bv);
    set_inputs(3'($urandom_range(0, 7)), rv, gv, bv);
  endtask

  // Scramble inputs without recording anything; must not reach the outputs.
  task automatic glitch_inputs();
    {RqFLag0, RqFLag1, RqFLag2} = 3'($urandom);
    {r0, g0, b0, r1, g1, b1} = 48'({$urandom, $urandom});
    {r2, g2, b2} = 24'($urandom);
  endtask

  // Monitor: compare after each edge, then again late in the cycle.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (rst_n === 1'b1 && q.size() > 0) begin
      e = q.pop_front();
      check("capture", dut_out(), e);
      #3;
      if (rst_n === 1'b1) check("hold", dut_out(), e);
    end
  end

  initial begin
    logic [2:0][7:0] rv, gv, bv;

    rst_n = 1'b1;
    RqFLag0 = 1'b0; RqFLag1 = 1'b0; RqFLag2 = 1'b0;
    {r0, g0, b0, r1, g1, b1, r2, g2, b2} = '0;

    // Asynchronous reset before any clock edge.
    #1 rst_n = 1'b0;
    glitch_inputs();
    #1 check_reset("reset_async");
    repeat (2) @(posedge clk);
    #1 check_reset("reset_held");

    // Release and directed cases.
    @(negedge clk);
    rst_n = 1'b1;
    rand_colours(rv, gv, bv);
    set_inputs(3'b000, rv, gv, bv);

    @(negedge clk);
    rand_colours(rv, gv, bv);
    rv[2] = 8'hFF; gv[2] = 8'h80; bv[2] = 8'h01;
    set_inputs(3'b100, rv, gv, bv);

    @(negedge clk);
    rand_colours(rv, gv, bv);
    rv[0] = 8'h11; gv[0] = 8'h22; bv[0] = 8'h33;
    rv[1] = 8'hAA; rv[2] = 8'h55;
    set_inputs(3'b111, rv, gv, bv);

    @(negedge clk);
    rand_colours(rv, gv, bv);
    rv[1] = 8'h0F; gv[1] = 8'hF0; bv[1] = 8'h3C;
    set_inputs(3'b110, rv, gv, bv);

    // Toggling flags every cycle.
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      rand_colours(rv, gv, bv);
      set_inputs((i % 2 == 0) ? 3'b001 : ((i % 4 == 1) ? 3'b100 : 3'b000), rv, gv, bv);
    end

    // Random traffic with mid-cycle input scrambling and a mid-stream reset.
    for (int i = 0; i < 300; i++) begin
      if (i == 150) begin
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset("reset_midstream");
        q.delete();
        repeat (2) @(posedge clk);
        glitch_inputs();
        #1 check_reset("reset_mid_held");
        @(negedge clk);
        rst_n = 1'b1;
        rand_inputs();
      end else begin
        @(negedge clk);
        rand_inputs();
      end
      @(posedge clk);
      #3 glitch_inputs();
    end

    // Drain: everything pushed must have been consumed.
    repeat (2) @(posedge clk);
    #6;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending entries, want 0", q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
